decr_pipe: RTL and testbench
============================

// Module: decr_pipe
// PURPOSE
//  Pipelined fast decrementor: computes out = in - 1 and the borrow flag (bw = 1 iff in == 0).
//  It is the down-direction counterpart of the team's fast incrementors.
//  Stage 1 splits the word at SPLIT: it decrements the low part and zero-detects it.
//  Stage 2 decrements the high part only when the low part borrowed.
//  Sits between pipeline-counter logic (PC/loop-count/timer) and its consumer.
//  Uses valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  16  operand width in bits; legal range 2..64
//  SPLIT   8  bits in low part; 1 <= SPLIT < WIDTH
// PORTS
//  clk        in   1      clock; all flops on rising edge
//  rst_n      in   1      asynchronous reset, active low
//  in_valid   in   1      input operand valid
//  in_ready   out  1      block can accept operand this cycle
//  in         in   WIDTH  operand
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result this cycle
//  out        out  WIDTH  in - 1 (mod 2^WIDTH, or saturated; see CONFIGURATION)
//  bw         out  1      borrow: operand was 0
// BEHAVIOUR
//  - Reset (async assert, sync deassert by caller): s1_valid=0, s2_valid=0, out_valid=0.
//    Also out=0, bw=0, and in_ready=1 once rst_n=1.
//  - Transfer on a side happens when valid && ready are both high in the same cycle.
//  - Stage 1 regs: hi = in[WIDTH-1:SPLIT], lo_dec = in[SPLIT-1:0]-1, lo_bw = (in[SPLIT-1:0]==0).
//  - Stage 2 regs: out = {lo_bw ? hi-1 : hi, lo_dec}; bw = lo_bw && (hi==0).
//  - Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held 1.
//  - Throughput: 1 result/cycle with no bubbles while out_ready=1.
//  - Stage advance: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en.
//  - in_ready = s1_en (combinational from out_ready; no skid buffer).
//  - Backpressure: while out_ready=0, out/bw/out_valid hold stable.
//    Upstream may fill stage 1, then in_ready=0.
//  - in_valid may drop without transfer; bubbles propagate as valid=0 and never
//    overwrite a held result.
//  - Simultaneous out transfer + new input with both stages full: everything shifts
//    in one cycle and nothing is lost or duplicated.
//  - Data regs load only on their stage enable with valid input; no X propagation
//    from an idle input.
//  - Wrap-around: in=0 -> out=all-ones, bw=1.
//    in=2^SPLIT (low part zero) -> out = 2^SPLIT-1, bw=0.
//  - Reset mid-operation: in-flight results are discarded.
//    out_valid=0 immediately on rst_n=0 (async).
// CONFIGURATION
//  DECR_PIPE_SATURATE_EN
//   - defined: for in==0 the result is out=0 with bw=1 (saturating count-down).
//   - undefined: modulo wrap, so in==0 gives out=2^WIDTH-1 with bw=1.
//   - All other operands give identical results either way.
// TESTING
//  1. Reset: rst_n=0 mid-stream with 2 items in flight.
//     -> out_valid=0 at once, in_ready=1 after release, no stale output.
//  2. Stream WIDTH=16: in=0x0005,0x0100,0xFFFF with out_ready=1.
//     -> out=0x0004,0x00FF,0xFFFE, bw=0, on cycles +2,+3,+4.
//  3. Zero operand in=0x0000.
//     -> out=0xFFFF bw=1 (default build); out=0x0000 bw=1 with DECR_PIPE_SATURATE_EN.
//  4. Backpressure: send 0x0010,0x0020,0x0030 with out_ready=0 for 5 cycles.
//     -> out=0x000F held, in_ready=0 after 2 accepted.
//     On release: 0x000F,0x001F,0x002F in order.
//  5. Split boundary: in=0x0100, 0x0001, 0x8000.
//     -> 0x00FF, 0x0000, 0x7FFF, bw=0 all.
//     Plus random 10k operands vs reference model with random valid/ready.
//  6. Param sweep: WIDTH=9/SPLIT=4 and WIDTH=32/SPLIT=16.
//     in=0x100 -> 0x0FF; in=0x00010000 -> 0x0000FFFF; in=0 -> all-ones, bw=1.

Source files
------------

// File: rtl/decr_pipe_if.sv
// Handshake bundle for decr_pipe: operand side (in_*) and result side (out_*, bw).
// The block itself uses the slave modport; its driver/consumer uses master.
interface decr_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             bw;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, bw
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, bw
  );
endinterface

// File: rtl/decr_pipe.sv
// decr_pipe: two-stage valid/ready decrementor, out = in - 1 with borrow flag when in == 0.
// Optional DECR_PIPE_SATURATE_EN: zero operand yields out = 0 (bw = 1) instead of all-ones.
module decr_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 8
) (
  input logic        clk,
  input logic        rst_n,
  decr_pipe_if.slave bus
);
  localparam int HIW = WIDTH - SPLIT;

  logic             s1_en;
  logic             s2_en;
  logic             hi_zero_s;
  logic             s1_valid_q, s1_valid_d;
  logic [HIW-1:0]   s1_hi_q, s1_hi_d;
  logic [SPLIT-1:0] s1_lo_dec_q, s1_lo_dec_d;
  logic             s1_lo_bw_q, s1_lo_bw_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_out_q, s2_out_d;
  logic             s2_bw_q, s2_bw_d;

  // Stage enables: a stage advances when it is empty or its successor advances.
  always_comb begin
    s2_en     = !s2_valid_q || bus.out_ready;
    s1_en     = !s1_valid_q || s2_en;
    hi_zero_s = (s1_hi_q == {HIW{1'b0}});
  end

  // Stage 1: split the operand, decrement and zero-detect the low part.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_hi_d     = s1_hi_q;
    s1_lo_dec_d = s1_lo_dec_q;
    s1_lo_bw_d  = s1_lo_bw_q;
    if (s1_en) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_hi_d     = bus.in_data[WIDTH-1:SPLIT];
        s1_lo_dec_d = bus.in_data[SPLIT-1:0] - SPLIT'(1'b1);
        s1_lo_bw_d  = (bus.in_data[SPLIT-1:0] == {SPLIT{1'b0}});
      end else begin
        s1_hi_d     = s1_hi_q;
        s1_lo_dec_d = s1_lo_dec_q;
        s1_lo_bw_d  = s1_lo_bw_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2: ripple the low-part borrow into the high part; bubbles never touch held data.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_out_d   = s2_out_q;
    s2_bw_d    = s2_bw_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_bw_d = s1_lo_bw_q && hi_zero_s;
`ifdef DECR_PIPE_SATURATE_EN
        if (s1_lo_bw_q && hi_zero_s) begin
          s2_out_d = {WIDTH{1'b0}};
        end else if (s1_lo_bw_q) begin
          s2_out_d = {s1_hi_q - HIW'(1'b1), s1_lo_dec_q};
        end else begin
          s2_out_d = {s1_hi_q, s1_lo_dec_q};
        end
`else
        if (s1_lo_bw_q) begin
          s2_out_d = {s1_hi_q - HIW'(1'b1), s1_lo_dec_q};
        end else begin
          s2_out_d = {s1_hi_q, s1_lo_dec_q};
        end
`endif
      end else begin
        s2_out_d = s2_out_q;
        s2_bw_d  = s2_bw_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_hi_q     <= {HIW{1'b0}};
      s1_lo_dec_q <= {SPLIT{1'b0}};
      s1_lo_bw_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_out_q    <= {WIDTH{1'b0}};
      s2_bw_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hi_q     <= s1_hi_d;
      s1_lo_dec_q <= s1_lo_dec_d;
      s1_lo_bw_q  <= s1_lo_bw_d;
      s2_valid_q  <= s2_valid_d;
      s2_out_q    <= s2_out_d;
      s2_bw_q     <= s2_bw_d;
    end
  end

  assign bus.in_ready  = s1_en;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_out_q;
  assign bus.bw        = s2_bw_q;
endmodule

// File: tb/tb_decr_pipe.sv
// Scoreboard bench for decr_pipe: directed scenarios, randomized traffic, and width/split variants.
module tb_decr_pipe;
`ifdef DECR_PIPE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decr_pipe_if #(.WIDTH(16)) bus ();
  decr_pipe_if #(.WIDTH(9))  bus9 ();
  decr_pipe_if #(.WIDTH(32)) bus32 ();

  decr_pipe #(.WIDTH(16), .SPLIT(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  decr_pipe #(.WIDTH(9),  .SPLIT(4))  dut9  (.clk(clk), .rst_n(rst_n), .bus(bus9));
  decr_pipe #(.WIDTH(32), .SPLIT(16)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit lat_chk = 1'b0;
  logic [16:0] exp_q[$];
  int          cin_q[$];
  bit          hold_pending = 1'b0;
  logic [16:0] hold_val;

  logic [8:0]  v9 [3];
  logic [8:0]  e9 [3];
  logic [31:0] v32 [3];
  logic [31:0] e32 [3];
  logic        ebw [3];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the whole word, independent of the split.
  function automatic logic [16:0] model16(input logic [15:0] v);
    if (v == 16'h0000) return {1'b1, (SAT ? 16'h0000 : 16'hFFFF)};
    else return {1'b0, v - 16'h0001};
  endfunction

  // Monitor: pops the scoreboard on each output transfer and checks hold stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending) begin
        chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("hold_data", {47'd0, bus.bw, bus.out_data}, {47'd0, hold_val});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got %0h expected none", bus.out_data);
        end else begin
          logic [16:0] e;
          int ci;
          e  = exp_q.pop_front();
          ci = cin_q.pop_front();
          chk("out_data", {48'd0, bus.out_data}, {48'd0, e[15:0]});
          chk("out_bw", {63'd0, bus.bw}, {63'd0, e[16]});
          if (lat_chk) chk("latency", 64'(cyc - ci), 64'd2);
        end
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      hold_val     = {bus.bw, bus.out_data};
    end else begin
      hold_pending = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the operand transferred.
  task automatic send(input logic [15:0] v);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model16(v));
        cin_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got no in_ready expected transfer of %0h", v);
    end
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = 16'h0000; bus.out_ready = 1'b0;
    bus9.in_valid = 1'b0; bus9.in_data = 9'h000; bus9.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_data = 32'h0; bus32.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", {48'd0, bus.out_data}, 64'd0);
    chk("rst_bw", {63'd0, bus.bw}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;

    // Reset with two items in flight.
    bus.out_ready = 1'b0;
    send(16'h1234);
    send(16'h0042);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_out_data", {48'd0, bus.out_data}, 64'd0);
    exp_q.delete();
    cin_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_stale", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk); #1;

    // Back-to-back stream with latency check.
    lat_chk = 1'b1;
    send(16'h0005); send(16'h0100); send(16'hFFFF);
    drain();
    lat_chk = 1'b0;

    // Zero operand.
    send(16'h0000);
    drain();

    // Backpressure: two accepted, third stalls, first result held.
    bus.out_ready = 1'b0;
    send(16'h0010);
    send(16'h0020);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0030;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_out_held", {48'd0, bus.out_data}, 64'h000F);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(16'h0030);
    drain();

    // Split boundary operands.
    send(16'h0100); send(16'h0001); send(16'h8000);
    drain();

    // Random traffic with random valid/ready.
    for (int i = 0; i < 12000; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: bus.in_data = 16'h0000;
        1: bus.in_data = {8'($urandom_range(0, 255)), 8'h00};
        2: bus.in_data = 16'hFFFF;
        default: bus.in_data = 16'($urandom);
      endcase
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model16(bus.in_data));
        cin_q.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    drain();

    // Width/split variants.
    v9[0] = 9'h100;  e9[0] = 9'h0FF;  v32[0] = 32'h0001_0000; e32[0] = 32'h0000_FFFF; ebw[0] = 1'b0;
    v9[1] = 9'h010;  e9[1] = 9'h00F;  v32[1] = 32'h1234_5678; e32[1] = 32'h1234_5677; ebw[1] = 1'b0;
    v9[2] = 9'h000;  e9[2] = SAT ? 9'h000 : 9'h1FF;
    v32[2] = 32'h0;  e32[2] = SAT ? 32'h0 : 32'hFFFF_FFFF; ebw[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus9.in_valid = 1'b1;  bus9.in_data = v9[i];
      bus32.in_valid = 1'b1; bus32.in_data = v32[i];
      @(posedge clk); #1;
      bus9.in_valid = 1'b0; bus32.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("w9_valid", {63'd0, bus9.out_valid}, 64'd1);
      chk("w9_out", {55'd0, bus9.out_data}, {55'd0, e9[i]});
      chk("w9_bw", {63'd0, bus9.bw}, {63'd0, ebw[i]});
      chk("w32_valid", {63'd0, bus32.out_valid}, 64'd1);
      chk("w32_out", {32'd0, bus32.out_data}, {32'd0, e32[i]});
      chk("w32_bw", {63'd0, bus32.bw}, {63'd0, ebw[i]});
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
